// File: rtl/fsk_frame_demod_if.sv
// Frame handshake bundle between the FSK receiver and the downstream decoder.
interface fsk_frame_demod_if #(
  parameter int FRAME_BITS = 14
);
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_err;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  overrun;

  modport master (
    output frame_data,
    output frame_err,
    output frame_valid,
    output overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_err,
    input  frame_valid,
    input  overrun,
    output frame_ready
  );
endinterface

// File: rtl/fsk_frame_demod.sv
// Edge-counting FSK frame receiver: counts rising edges of the asynchronous line in
// fixed bit windows, decides each bit against two thresholds (ambiguous = erasure),
// packs FRAME_BITS decisions into a frame and offers it on a valid/ready interface.
module fsk_frame_demod #(
  parameter int FRAME_BITS   = 14,
  parameter int CLKS_PER_BIT = 64,
  parameter int CNT_W        = 6,
  parameter int LO_MAX       = 2,
  parameter int HI_MIN       = 4,
  parameter int MSB_FIRST    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 fsk_in,
  fsk_frame_demod_if.master    frm
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [TW-1:0]    TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]    ILAST = IW'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] HI_T  = CNT_W'(HI_MIN);
  localparam logic [CNT_W-1:0] LO_T  = CNT_W'(LO_MAX);

  // Receiver modes; en alone selects between them, so no separate state register
  // is needed: idle clears the datapath every cycle, so the first en=1 cycle is
  // already window 0 at timer 0.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RX   = 1'b1;

  logic                  s1, s2, s3;
  logic                  rise;
  logic [0:0]            mode;
  logic [TW-1:0]         timer;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_fin;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         pos;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_next;
  logic                  acc;
  logic                  bit_val;
  logic                  bit_era;
  logic                  win_end;
  logic                  frame_done;

  // Two-flop synchroniser plus a delay stage for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= fsk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Window end decision, saturating count, bit placement and frame completion
  always_comb begin
    rise       = s2 & ~s3;
    mode       = en ? RX : IDLE;
    cnt_fin    = (rise && (cnt != '1)) ? cnt + 1'b1 : cnt;
    win_end    = (mode == RX) && (timer == TLAST);
    bit_val    = (cnt_fin >= HI_T);
    bit_era    = !bit_val && (cnt_fin > LO_T);
    pos        = (MSB_FIRST != 0) ? (ILAST - idx) : idx;
    frame_next = shreg;
    frame_next[pos] = bit_val;
    frame_done = win_end && (idx == ILAST);
  end

  // Bit timer, edge counter and frame assembly; all held at zero while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      acc   <= 1'b0;
    end else if (mode == IDLE) begin
      timer <= '0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      acc   <= 1'b0;
    end else if (win_end) begin
      timer <= '0;
      cnt   <= '0;
      if (frame_done) begin
        idx   <= '0;
        shreg <= '0;
        acc   <= 1'b0;
      end else begin
        idx   <= idx + 1'b1;
        shreg <= frame_next;
        acc   <= acc | bit_era;
      end
    end else begin
      timer <= timer + 1'b1;
      cnt   <= cnt_fin;
    end
  end

  // Output holding register: load when free or being accepted, else drop and flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm.frame_data  <= '0;
      frm.frame_err   <= 1'b0;
      frm.frame_valid <= 1'b0;
      frm.overrun     <= 1'b0;
    end else begin
      frm.overrun <= 1'b0;
      if (frame_done) begin
        if (!frm.frame_valid || frm.frame_ready) begin
          frm.frame_data  <= frame_next;
          frm.frame_err   <= acc | bit_era;
          frm.frame_valid <= 1'b1;
        end else begin
          frm.overrun <= 1'b1;
        end
      end else if (frm.frame_ready) begin
        frm.frame_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fsk_frame_demod.sv
// Randomised bench for fsk_frame_demod: two instances (LSB-first with a wide
// counter, MSB-first with a 3-bit counter so saturation is observable) share one
// stimulus stream; each is scored against a per-frame count-based reference.
module tb_fsk_frame_demod;
  localparam int FB  = 14;
  localparam int CPB = 64;
  localparam int HI  = 4;
  localparam int LO  = 2;

  typedef int cnt_t [FB];

  logic clk = 1'b0;
  logic reset, en, fsk_in, ready;

  int n_checks = 0;
  int n_err    = 0;
  int ovr_a    = 0;
  int ovr_b    = 0;
  int exp_ovr  = 0;

  logic [FB:0] qa[$];
  logic [FB:0] qb[$];

  always #5 clk = ~clk;

  fsk_frame_demod_if #(.FRAME_BITS(FB)) ifa ();
  fsk_frame_demod_if #(.FRAME_BITS(FB)) ifb ();
  assign ifa.frame_ready = ready;
  assign ifb.frame_ready = ready;

  fsk_frame_demod #(.FRAME_BITS(FB), .CLKS_PER_BIT(CPB), .CNT_W(6), .LO_MAX(LO),
                    .HI_MIN(HI), .MSB_FIRST(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .fsk_in(fsk_in), .frm(ifa.master));

  fsk_frame_demod #(.FRAME_BITS(FB), .CLKS_PER_BIT(CPB), .CNT_W(3), .LO_MAX(LO),
                    .HI_MIN(HI), .MSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .fsk_in(fsk_in), .frm(ifb.master));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: per bit, clamp the edge count to the counter range, then threshold
  function automatic logic [FB:0] model(input cnt_t c, input int cw, input bit msb);
    logic [FB-1:0] d;
    logic          e;
    int            cmax;
    int            sat;
    d    = '0;
    e    = 1'b0;
    cmax = (1 << cw) - 1;
    for (int i = 0; i < FB; i++) begin
      sat = (c[i] > cmax) ? cmax : c[i];
      if (sat >= HI) d[msb ? FB - 1 - i : i] = 1'b1;
      else if (sat > LO) e = 1'b1;
    end
    return {e, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One slot per clock; window b gets c[b] single-cycle pulses starting at offset 4
  task automatic drive(input cnt_t c, input int nslots, input bit pulse);
    for (int s = 0; s < nslots; s++) begin
      int b = s / CPB;
      int t = s % CPB;
      fsk_in = (t >= 4 && t < 4 + 2 * c[b] && ((t - 4) % 2 == 0)) ? 1'b1 : 1'b0;
      if (pulse && s == nslots - 1) ready = 1'b1;
      tick();
    end
    fsk_in = 1'b0;
  endtask

  task automatic run_frame(input cnt_t c, input bit deliver, input bit pulse);
    if (deliver) begin
      qa.push_back(model(c, 6, 1'b0));
      qb.push_back(model(c, 3, 1'b1));
    end else begin
      exp_ovr++;
    end
    drive(c, FB * CPB, pulse);
  endtask

  task automatic gap(input int n);
    en     = 1'b0;
    fsk_in = 1'b0;
    repeat (n) tick();
    en = 1'b1;
  endtask

  task automatic check_idle();
    check("a_data_idle",    ifa.frame_data,  0);
    check("a_err_idle",     ifa.frame_err,   0);
    check("a_valid_idle",   ifa.frame_valid, 0);
    check("a_overrun_idle", ifa.overrun,     0);
    check("b_data_idle",    ifb.frame_data,  0);
    check("b_err_idle",     ifb.frame_err,   0);
    check("b_valid_idle",   ifb.frame_valid, 0);
    check("b_overrun_idle", ifb.overrun,     0);
  endtask

  function automatic cnt_t clean_frame();
    cnt_t c;
    for (int i = 0; i < FB; i++) c[i] = ($urandom_range(0, 1) == 1) ? 6 : 1;
    return c;
  endfunction

  function automatic cnt_t rand_frame();
    cnt_t c;
    int   set[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 20};
    for (int i = 0; i < FB; i++) c[i] = set[$urandom_range(0, 8)];
    return c;
  endfunction

  // Scoreboard for instance A: every valid cycle must show the oldest expected frame
  always @(negedge clk) begin
    if (ifa.overrun === 1'b1) ovr_a++;
    if (ifa.frame_valid === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_frame_pending", qa.size(), 1);
      end else begin
        check("a_frame_data", ifa.frame_data, qa[0][FB-1:0]);
        check("a_frame_err",  ifa.frame_err,  qa[0][FB]);
        if (ready) void'(qa.pop_front());
      end
    end
  end

  // Scoreboard for instance B
  always @(negedge clk) begin
    if (ifb.overrun === 1'b1) ovr_b++;
    if (ifb.frame_valid === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_frame_pending", qb.size(), 1);
      end else begin
        check("b_frame_data", ifb.frame_data, qb[0][FB-1:0]);
        check("b_frame_err",  ifb.frame_err,  qb[0][FB]);
        if (ready) void'(qb.pop_front());
      end
    end
  end

  initial begin
    cnt_t c;
    reset  = 1'b1;
    en     = 1'b0;
    fsk_in = 1'b0;
    ready  = 1'b1;
    repeat (3) tick();
    check_idle();
    reset = 1'b0;
    tick();

    // Ten clean frames back to back
    en = 1'b1;
    for (int f = 0; f < 10; f++) run_frame(clean_frame(), 1'b1, 1'b0);

    // Single ambiguous bit, then a clean frame
    c = clean_frame();
    c[5] = 3;
    run_frame(c, 1'b1, 1'b0);
    run_frame(clean_frame(), 1'b1, 1'b0);

    // Threshold boundaries and counter saturation
    c = clean_frame();
    c[0] = 2;  c[1] = 4;  c[2] = 8;  c[3] = 20;  c[4] = 7;
    run_frame(c, 1'b1, 1'b0);

    // LSB-first 14'h0001 / MSB-first 14'h2000
    c = '{default: 1};
    c[0] = 6;
    run_frame(c, 1'b1, 1'b0);

    // Consumer stalled over two completions: first held, second dropped
    gap(4);
    ready = 1'b0;
    run_frame(clean_frame(), 1'b1, 1'b0);
    run_frame(clean_frame(), 1'b0, 1'b0);
    gap(6);
    ready = 1'b1;
    gap(4);

    // Acceptance in exactly the completion cycle
    ready = 1'b0;
    run_frame(clean_frame(), 1'b1, 1'b0);
    run_frame(clean_frame(), 1'b1, 1'b1);
    ready = 1'b1;
    gap(4);

    // Enable dropped partway through bit 7, then a fresh aligned frame
    drive(clean_frame(), 7 * CPB + 20, 1'b0);
    gap(40);
    run_frame(clean_frame(), 1'b1, 1'b0);

    // Reset while a frame is held and another is half received
    gap(4);
    ready = 1'b0;
    run_frame(clean_frame(), 1'b1, 1'b0);
    drive(clean_frame(), 3 * CPB + 10, 1'b0);
    reset = 1'b1;
    en    = 1'b0;
    #1;
    check_idle();
    qa.delete();
    qb.delete();
    repeat (3) tick();
    reset = 1'b0;
    ready = 1'b1;
    tick();

    // Randomised counts including erasures and saturation
    en = 1'b1;
    for (int f = 0; f < 6; f++) run_frame(rand_frame(), 1'b1, 1'b0);

    en = 1'b0;
    repeat (10) tick();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("a_overrun_count", ovr_a, exp_ovr);
    check("b_overrun_count", ovr_b, exp_ovr);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
